// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection for a 5-stage in-order pipeline: RAW stalls, taken-branch flushes,
// operand forwarding selects and stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter bit FWD_EN = 1'b0,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_re1,
  input  logic             id_re2,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             ex_we,
  input  logic             mem_we,
  input  logic             wb_we,
  input  logic             ex_is_load,
  input  logic             ex_br_taken,
  output logic             data_hazard,
  output logic             control_hazard,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_t;

  state_t cur_state, next_state;
  logic   ex_m1, mem_m1, wb_m1;
  logic   ex_m2, mem_m2, wb_m2;
  logic   raw;

  function automatic logic src_match(input logic re, input logic [4:0] rs,
                                     input logic we, input logic [4:0] rd);
    return re && (rs != 5'd0) && we && (rd == rs);
  endfunction

  // A load still in EX has no data to forward yet, so only a non-load EX producer is bypassed.
  function automatic logic [1:0] fwd_sel(input logic ex_m, input logic mem_m, input logic ex_load);
    if (!FWD_EN)
      return 2'b00;
    else if (ex_m && !ex_load)
      return 2'b01;
    else if (mem_m)
      return 2'b10;
    else
      return 2'b00;
  endfunction

  always_comb begin
    ex_m1  = src_match(id_re1, id_rs1, ex_we,  ex_rd);
    mem_m1 = src_match(id_re1, id_rs1, mem_we, mem_rd);
    wb_m1  = src_match(id_re1, id_rs1, wb_we,  wb_rd);
    ex_m2  = src_match(id_re2, id_rs2, ex_we,  ex_rd);
    mem_m2 = src_match(id_re2, id_rs2, mem_we, mem_rd);
    wb_m2  = src_match(id_re2, id_rs2, wb_we,  wb_rd);

    if (FWD_EN)
      raw = id_valid && ex_is_load && (ex_m1 || ex_m2);
    else
      raw = id_valid && (ex_m1 || mem_m1 || wb_m1 || ex_m2 || mem_m2 || wb_m2);

    // ID holds a flushed bubble while in FLUSH, and a redirect always beats a stall.
    control_hazard = ex_br_taken;
    data_hazard    = raw && !ex_br_taken && (cur_state != FLUSH);
    ifid_flush     = control_hazard;
    idex_flush     = control_hazard || data_hazard;
    fwd_a          = fwd_sel(ex_m1, mem_m1, ex_is_load);
    fwd_b          = fwd_sel(ex_m2, mem_m2, ex_is_load);
    state          = cur_state;

    // Every state follows the same priority: redirect, then stall, then run.
    next_state = RUN;
    if (ex_br_taken)
      next_state = FLUSH;
    else if (data_hazard)
      next_state = STALL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      cur_state <= next_state;
      stall_cnt <= stall_cnt + CNT_W'(data_hazard);
      flush_cnt <= flush_cnt + CNT_W'(control_hazard);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: one instance without forwarding (32-bit counters) and one with
// forwarding (4-bit counters so wrap-around is reachable), both driven by the same inputs.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       id_valid, id_re1, id_re2, ex_we, mem_we, wb_we, ex_is_load, ex_br_taken;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;

  logic [1:0]  dh, ch, ifl, idf;
  logic [1:0]  fa [2];
  logic [1:0]  fb [2];
  logic [1:0]  st [2];
  logic [31:0] sc0, fc0;
  logic [3:0]  sc1, fc1;

  pipe_hazard_ctrl #(.FWD_EN(1'b0), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_re1(id_re1), .id_re2(id_re2), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we), .ex_is_load(ex_is_load),
    .ex_br_taken(ex_br_taken), .data_hazard(dh[0]), .control_hazard(ch[0]),
    .ifid_flush(ifl[0]), .idex_flush(idf[0]), .fwd_a(fa[0]), .fwd_b(fb[0]),
    .state(st[0]), .stall_cnt(sc0), .flush_cnt(fc0)
  );

  pipe_hazard_ctrl #(.FWD_EN(1'b1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_re1(id_re1), .id_re2(id_re2), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we), .ex_is_load(ex_is_load),
    .ex_br_taken(ex_br_taken), .data_hazard(dh[1]), .control_hazard(ch[1]),
    .ifid_flush(ifl[1]), .idex_flush(idf[1]), .fwd_a(fa[1]), .fwd_b(fb[1]),
    .state(st[1]), .stall_cnt(sc1), .flush_cnt(fc1)
  );

  int     total = 0;
  int     bad = 0;
  bit     cmp_on = 1'b0;
  longint m_st [2];
  longint m_sc [2];
  longint m_fc [2];

  task automatic checkOutput(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint modw(input int i);
    return (i == 0) ? 64'h1_0000_0000 : 64'd16;
  endfunction

  function automatic longint get_sc(input int i);
    return (i == 0) ? longint'(sc0) : longint'(sc1);
  endfunction

  function automatic longint get_fc(input int i);
    return (i == 0) ? longint'(fc0) : longint'(fc1);
  endfunction

  // Reference: scan both sources against the three producer stages in a table.
  function automatic void predict(input int fe, input longint cur_st, output bit edh,
                                  output bit ech, output logic [1:0] efa, output logic [1:0] efb);
    logic [4:0] rd [3];
    bit         we [3];
    logic [4:0] rs [2];
    bit         re [2];
    bit         m [2][3];
    bit         raw;
    logic [1:0] f [2];
    rd = '{ex_rd, mem_rd, wb_rd};
    we = '{ex_we, mem_we, wb_we};
    rs = '{id_rs1, id_rs2};
    re = '{id_re1, id_re2};
    raw = 1'b0;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 3; k++) begin
        m[s][k] = re[s] && (rs[s] != 0) && we[k] && (rd[k] == rs[s]);
        if (fe == 0 && m[s][k]) raw = 1'b1;
        if (fe == 1 && k == 0 && m[s][k] && ex_is_load) raw = 1'b1;
      end
      f[s] = 2'd0;
      if (fe == 1) begin
        if (m[s][0] && !ex_is_load) f[s] = 2'd1;
        else if (m[s][1]) f[s] = 2'd2;
      end
    end
    if (!id_valid || cur_st == 2) raw = 1'b0;
    edh = raw && !ex_br_taken;
    ech = ex_br_taken;
    efa = f[0];
    efb = f[1];
  endfunction

  bit         u_dh, u_ch;
  logic [1:0] u_fa, u_fb;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_st[i] <= 0;
        m_sc[i] <= 0;
        m_fc[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        predict(i, m_st[i], u_dh, u_ch, u_fa, u_fb);
        m_st[i] <= u_ch ? 2 : (u_dh ? 1 : 0);
        m_sc[i] <= (m_sc[i] + longint'(u_dh)) % modw(i);
        m_fc[i] <= (m_fc[i] + longint'(u_ch)) % modw(i);
      end
    end
  end

  bit         c_dh, c_ch;
  logic [1:0] c_fa, c_fb;
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int i = 0; i < 2; i++) begin
        predict(i, m_st[i], c_dh, c_ch, c_fa, c_fb);
        checkOutput($sformatf("dut%0d data_hazard", i), dh[i], c_dh);
        checkOutput($sformatf("dut%0d control_hazard", i), ch[i], c_ch);
        checkOutput($sformatf("dut%0d ifid_flush", i), ifl[i], c_ch);
        checkOutput($sformatf("dut%0d idex_flush", i), idf[i], c_ch | c_dh);
        checkOutput($sformatf("dut%0d fwd_a", i), fa[i], c_fa);
        checkOutput($sformatf("dut%0d fwd_b", i), fb[i], c_fb);
        checkOutput($sformatf("dut%0d state", i), st[i], m_st[i]);
        checkOutput($sformatf("dut%0d stall_cnt", i), get_sc(i), m_sc[i]);
        checkOutput($sformatf("dut%0d flush_cnt", i), get_fc(i), m_fc[i]);
      end
    end
  end

  task automatic clearInputs();
    id_valid = 0; id_re1 = 0; id_re2 = 0; ex_we = 0; mem_we = 0; wb_we = 0;
    ex_is_load = 0; ex_br_taken = 0;
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic applyStimulus();
    rst         = ($urandom_range(0, 199) != 0);
    id_valid    = ($urandom_range(0, 7) != 0);
    id_re1      = ($urandom_range(0, 3) != 0);
    id_re2      = ($urandom_range(0, 3) != 0);
    ex_we       = ($urandom_range(0, 3) != 0);
    mem_we      = ($urandom_range(0, 3) != 0);
    wb_we       = ($urandom_range(0, 3) != 0);
    ex_is_load  = ($urandom_range(0, 2) == 0);
    ex_br_taken = ($urandom_range(0, 7) == 0);
    id_rs1      = 5'($urandom_range(0, 3));
    id_rs2      = 5'($urandom_range(0, 3));
    ex_rd       = 5'($urandom_range(0, 3));
    mem_rd      = 5'($urandom_range(0, 3));
    wb_rd       = 5'($urandom_range(0, 3));
  endtask

  initial begin
    clearInputs();
    cmp_on = 1'b1;
    sample();
    checkOutput("reset state", st[0], 0);
    checkOutput("reset stall_cnt", sc0, 0);
    tick();
    rst = 1'b1;

    // Non-forwarding RAW against EX for three cycles.
    doReset();
    id_valid = 1; id_rs1 = 5; id_re1 = 1; ex_rd = 5; ex_we = 1;
    for (int k = 0; k < 3; k++) begin
      sample();
      checkOutput("s1 data_hazard", dh[0], 1);
      tick();
    end
    clearInputs();
    sample();
    checkOutput("s1 state stall", st[0], 1);
    checkOutput("s1 stall_cnt", sc0, 3);
    checkOutput("s1 hazard gone", dh[0], 0);
    tick();
    sample();
    checkOutput("s1 back to run", st[0], 0);

    // Load-use then the loaded value becomes forwardable from EX.
    doReset();
    id_valid = 1; ex_rd = 7; ex_we = 1; ex_is_load = 1; id_rs2 = 7; id_re2 = 1;
    sample();
    checkOutput("s2 load-use", dh[1], 1);
    tick();
    ex_is_load = 0;
    sample();
    checkOutput("s2 no hazard", dh[1], 0);
    checkOutput("s2 fwd_b ex", fb[1], 1);

    // Forwarding priority: EX over MEM, and x0 never forwards.
    doReset();
    clearInputs();
    id_valid = 1; mem_rd = 3; mem_we = 1; id_rs1 = 3; id_re1 = 1; ex_rd = 3; ex_we = 1;
    sample();
    checkOutput("s3 fwd_a ex wins", fa[1], 1);
    tick();
    ex_we = 0;
    sample();
    checkOutput("s3 fwd_a mem", fa[1], 2);
    tick();
    id_rs1 = 0; mem_rd = 0;
    sample();
    checkOutput("s3 fwd_a x0", fa[1], 0);

    // Load-use coinciding with a taken branch, then the bubble masked in FLUSH.
    doReset();
    clearInputs();
    id_valid = 1; id_rs1 = 4; id_re1 = 1; ex_rd = 4; ex_we = 1; ex_is_load = 1; ex_br_taken = 1;
    sample();
    checkOutput("s4 control_hazard", ch[1], 1);
    checkOutput("s4 ifid_flush", ifl[1], 1);
    checkOutput("s4 idex_flush", idf[1], 1);
    checkOutput("s4 data_hazard", dh[1], 0);
    tick();
    ex_br_taken = 0;
    sample();
    checkOutput("s4 state flush", st[1], 2);
    checkOutput("s4 flush_cnt", fc1, 1);
    checkOutput("s5 masked in flush", dh[1], 0);
    tick();
    sample();
    checkOutput("s5 hazard after flush", dh[1], 1);

    // Asynchronous reset in the middle of a stall.
    doReset();
    clearInputs();
    id_valid = 1; id_rs1 = 5; id_re1 = 1; ex_rd = 5; ex_we = 1;
    tick();
    tick();
    sample();
    checkOutput("s6 stall_cnt before", sc0, 2);
    checkOutput("s6 state before", st[0], 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("s6 async state", st[0], 0);
    checkOutput("s6 async stall_cnt", sc0, 0);
    checkOutput("s6 async flush_cnt", fc0, 0);
    tick();
    rst = 1'b1;

    // Back-to-back branches: FLUSH holds, 4-bit counter wraps after 16.
    doReset();
    clearInputs();
    ex_br_taken = 1;
    repeat (17) tick();
    sample();
    checkOutput("wrap flush_cnt 4b", fc1, 1);
    checkOutput("wide flush_cnt", fc0, 17);
    checkOutput("stay flush", st[1], 2);
    checkOutput("b2b control_hazard", ch[1], 1);
    tick();

    repeat (3000) begin
      applyStimulus();
      tick();
    end

    rst = 1'b1;
    clearInputs();
    sample();
    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter FWD_EN, default 0: 1 = EX/MEM and MEM/WB forwarding present, so only load-use stalls; 0 = stall on any RAW hazard.
REQ-002 Parameter CNT_W, default 32: width of the performance counters.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 id_valid  in  1  ID stage holds a real instruction.
REQ-006 id_rs1, id_rs2  in  5 each  ID source register indices.
REQ-007 id_re1, id_re2  in  1 each  ID actually reads rs1/rs2.
REQ-008 ex_rd, mem_rd, wb_rd  in  5 each  destination register per stage.
REQ-009 ex_we, mem_we, wb_we  in  1 each  register write enable per stage.
REQ-010 ex_is_load  in  1  EX-stage instruction is a load.
REQ-011 ex_br_taken  in  1  EX resolved a taken branch or jump.
REQ-012 data_hazard  out  1  hold PC and IF/ID; insert bubble into ID/EX.
REQ-013 control_hazard  out  1  PC takes the redirect npc; flush IF/ID and ID/EX.
REQ-014 ifid_flush, idex_flush  out  1 each  pipeline-register flush strobes.
REQ-015 fwd_a, fwd_b  out  2 each  00 = regfile, 01 = EX/MEM, 10 = MEM/WB.
REQ-016 state  out  2  00 RUN, 01 STALL, 10 FLUSH.
REQ-017 stall_cnt, flush_cnt  out  CNT_W each  cycles spent stalled / flushes taken.

Function
REQ-018 A match on source s SHALL require id_re_s, id_rs_s != 0, the stage's we asserted, and the stage's rd == id_rs_s.
REQ-019 raw SHALL be id_valid AND a match on either source, as follows:
- FWD_EN=0: a match against EX, MEM or WB.
- FWD_EN=1: a match against EX with ex_is_load asserted.
REQ-020 control_hazard SHALL equal ex_br_taken combinationally, with zero latency.
REQ-021 data_hazard SHALL equal raw AND NOT ex_br_taken AND (state != FLUSH); control_hazard has priority.
REQ-022 ifid_flush SHALL equal control_hazard.
REQ-023 idex_flush SHALL equal control_hazard OR data_hazard.
REQ-024 fwd_a/fwd_b SHALL be 00 when FWD_EN=0. When FWD_EN=1:
- 01 on an EX match with ex_is_load=0.
- Otherwise 10 on a MEM match.
- Otherwise 00.
- EX priority over MEM; rs=0 always gives 00.
REQ-025 FSM transitions, evaluated at each posedge:
- RUN: ex_br_taken -> FLUSH; else data_hazard -> STALL; else stay RUN.
- STALL: ex_br_taken -> FLUSH; else data_hazard -> stay STALL; else RUN.
- FLUSH: ex_br_taken -> stay FLUSH; else data_hazard -> STALL; else RUN.
REQ-026 In FLUSH, ID holds a flushed bubble, so raw SHALL be masked for that cycle regardless of id_valid.
REQ-027 stall_cnt SHALL increment by 1 on every cycle with data_hazard=1.
REQ-028 flush_cnt SHALL increment by 1 on every cycle with control_hazard=1.
REQ-029 Both counters SHALL wrap modulo 2^CNT_W without saturating.
REQ-030 A simultaneous raw and ex_br_taken SHALL produce:
- control_hazard=1, data_hazard=0;
- flush_cnt increments, stall_cnt does not.
REQ-031 A back-to-back taken branch in FLUSH SHALL keep control_hazard=1 and increment flush_cnt each cycle.

Reset
REQ-032 While rst=0, the block SHALL hold:
- state=RUN, stall_cnt=0, flush_cnt=0;
- combinational outputs evaluated with state=RUN.
REQ-033 Reset SHALL take effect asynchronously, including mid-STALL or mid-FLUSH, and SHALL be released synchronously on the first posedge with rst=1.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- FWD_EN=0; id_rs1=5, id_re1=1, ex_rd=5, ex_we=1 for 3 cycles -> data_hazard=1 for 3 cycles, state=STALL, stall_cnt=3, then RUN.
- FWD_EN=1; ex_rd=7, ex_is_load=1, id_rs2=7, id_re2=1 for 1 cycle, then ex_is_load=0 with ex_rd=7 -> data_hazard=1 for one cycle, then fwd_b=01, data_hazard=0.
- FWD_EN=1; mem_rd=3, mem_we=1, id_rs1=3; ex_rd=3, ex_we=1 -> fwd_a=01 (EX wins); with ex_we=0 -> fwd_a=10; with id_rs1=0 -> fwd_a=00.
- Load-use hazard with ex_br_taken=1 in the same cycle -> control_hazard=1, ifid_flush=1, idex_flush=1, data_hazard=0, state FLUSH next cycle, flush_cnt=1.
- Enter FLUSH with id_valid=1 and a matching rs -> data_hazard=0 in the FLUSH cycle, =1 the following cycle.
- rst=0 asserted mid-STALL with stall_cnt=2 -> state=RUN and counters=0 immediately, before the next clock edge.
